aes_op_sequencer: RTL
=====================

AES_OP_SEQUENCER -- requirements
Module: aes_op_sequencer

Interface
REQ-001 The block SHALL have parameter pPT_WIDTH, default 128, plaintext width.
REQ-002 The block SHALL have parameter pCT_WIDTH, default 128, ciphertext width.
REQ-003 The block SHALL have parameter pKEY_WIDTH, default 128, key width.
REQ-004 The block SHALL have parameter pRUN_TIMEOUT, default 200, the maximum core-busy cycles before the operation aborts.
REQ-005 The block SHALL have one clock and a synchronous active-high reset.
REQ-006 crypto_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 reset_i  in  1  synchronous active-high reset.
REQ-008 start_i  in  1  operation request from the register block, sampled in IDLE only.
REQ-009 key_i  in  pKEY_WIDTH  key, captured when start_i is accepted.
REQ-010 text_i  in  pPT_WIDTH  plaintext, captured when start_i is accepted.
REQ-011 ready_o  out  1  high only in IDLE.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 done_o  out  1  one-cycle completion pulse, on success or abort.
REQ-014 cipher_o  out  pCT_WIDTH  last successful ciphertext, held until the next success.
REQ-015 cycles_o  out  8  busy-cycle count of the last completed or aborted operation.
REQ-016 timeout_o  out  1  sticky abort flag.
REQ-017 trigger_o  out  1  scope trigger; high in LOAD, WAIT_BUSY and RUN.
REQ-018 aes_load_o  out  1  load strobe to the AES core.
REQ-019 aes_key_o  out  pKEY_WIDTH  latched key to the core.
REQ-020 aes_data_o  out  pPT_WIDTH  latched plaintext to the core.
REQ-021 aes_data_i  in  pCT_WIDTH  ciphertext from the core.
REQ-022 aes_busy_i  in  1  core busy flag.

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD, WAIT_BUSY, RUN and CAPTURE.
REQ-024 In IDLE with start_i=1, the block SHALL latch key_i/text_i into aes_key_o/aes_data_o, clear the busy counter and timeout_o, and go to LOAD next cycle.
REQ-025 start_i outside IDLE SHALL be ignored, with no latching and no queueing.
REQ-026 In LOAD, aes_load_o SHALL be 1 for exactly one cycle, then the FSM goes to WAIT_BUSY; aes_load_o SHALL be 0 in all other states.
REQ-027 aes_key_o/aes_data_o SHALL stay stable from LOAD until the FSM returns to IDLE.
REQ-028 In WAIT_BUSY, aes_busy_i=1 SHALL move the FSM to RUN and count that cycle.
REQ-029 In RUN, each cycle with aes_busy_i=1 SHALL increment the 8-bit busy counter, saturating at 255.
REQ-030 In RUN, aes_busy_i=0 SHALL move the FSM to CAPTURE.
REQ-031 In CAPTURE, the block SHALL set cipher_o<=aes_data_i and cycles_o<=counter, pulse done_o, and return to IDLE.
REQ-032 Latency from start_i accepted at cycle N: aes_load_o at N+1; done_o one cycle after the first cycle where aes_busy_i is sampled 0 in RUN.
REQ-033 If aes_busy_i=1 and aes_load_o=1 in the same cycle, aes_busy_i SHALL be ignored in that cycle.

Reset
REQ-034 reset_i=1 SHALL force IDLE and zero every output except ready_o, which is 1, and SHALL take priority over all other inputs, including mid-operation.
REQ-035 A reset mid-operation SHALL NOT produce a done_o pulse and SHALL NOT update cipher_o.

Configuration
REQ-036 The macro AES_SEQ_WATCHDOG_EN SHALL compile the watchdog in or out.
REQ-037 With AES_SEQ_WATCHDOG_EN defined, the watchdog SHALL abort when WAIT_BUSY lasts 4 cycles without aes_busy_i, or when the counter reaches pRUN_TIMEOUT while aes_busy_i=1.
REQ-038 An abort SHALL set timeout_o, set cycles_o<=counter, pulse done_o, leave cipher_o unchanged, and return to IDLE.
REQ-039 Without AES_SEQ_WATCHDOG_EN, WAIT_BUSY and RUN SHALL wait indefinitely, and timeout_o SHALL be tied 0.

Verification
REQ-040 Success case: key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, core model busy 11 cycles returning 69c4e0d86a7b0430d8cdb78070b4c55a -> cipher_o equals that value, cycles_o=11, one done_o pulse, timeout_o=0.
REQ-041 start_i pulsed during RUN with a different key -> ignored; aes_key_o unchanged; exactly one done_o.
REQ-042 reset_i asserted during RUN at busy-cycle 5 -> IDLE next cycle, ready_o=1, no done_o, cipher_o=0.
REQ-043 Watchdog enabled, core never raises busy -> done_o 5 cycles after aes_load_o, timeout_o=1, cycles_o=0; next start clears timeout_o.
REQ-044 Watchdog enabled, busy held high -> abort with cycles_o=200 and timeout_o=1; with watchdog disabled, the FSM stays in RUN, counter saturates at 255, and no done_o occurs.
REQ-045 Back-to-back operations: start_i on the cycle done_o falls -> accepted; second cipher_o replaces the first.

Source files
------------

// File: rtl/aes_op_sequencer.sv
// rtl/aes_op_sequencer.sv - AES core operation sequencer (optional watchdog: AES_SEQ_WATCHDOG_EN)
module aes_op_sequencer #(
  parameter int pPT_WIDTH    = 128,
  parameter int pCT_WIDTH    = 128,
  parameter int pKEY_WIDTH   = 128,
  parameter int pRUN_TIMEOUT = 200
) (
  input  logic                  crypto_clk,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [pKEY_WIDTH-1:0] key_i,
  input  logic [pPT_WIDTH-1:0]  text_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [pCT_WIDTH-1:0]  cipher_o,
  output logic [7:0]            cycles_o,
  output logic                  timeout_o,
  output logic                  trigger_o,
  output logic                  aes_load_o,
  output logic [pKEY_WIDTH-1:0] aes_key_o,
  output logic [pPT_WIDTH-1:0]  aes_data_o,
  input  logic [pCT_WIDTH-1:0]  aes_data_i,
  input  logic                  aes_busy_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_RUN,
    S_CAPTURE
  } state_t;

  state_t     state;
  logic [7:0] busy_cnt;
  logic [7:0] cnt_inc;

  // Next busy-cycle count, saturating at 255
  assign cnt_inc = (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;

`ifdef AES_SEQ_WATCHDOG_EN
  // The counter is 8 bits wide, so a larger limit behaves like 255
  localparam int         RUN_LIMIT_INT = (pRUN_TIMEOUT > 255) ? 255 : pRUN_TIMEOUT;
  localparam logic [7:0] RUN_LIMIT     = RUN_LIMIT_INT[7:0];

  logic [1:0] wait_cnt;
  logic       timeout_q;

  // Sticky abort flag comes straight from its register
  assign timeout_o = timeout_q;
`else
  // No watchdog: an operation can never abort
  assign timeout_o = 1'b0;
`endif

  // Operation FSM; results are registered on the edge that leaves RUN so that
  // done_o, cipher_o and cycles_o are presented together during CAPTURE
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state      <= S_IDLE;
      busy_cnt   <= 8'd0;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      cipher_o   <= '0;
      cycles_o   <= 8'd0;
      trigger_o  <= 1'b0;
      aes_load_o <= 1'b0;
      aes_key_o  <= '0;
      aes_data_o <= '0;
`ifdef AES_SEQ_WATCHDOG_EN
      wait_cnt   <= 2'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      done_o     <= 1'b0;
      aes_load_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            aes_key_o  <= key_i;
            aes_data_o <= text_i;
            busy_cnt   <= 8'd0;
`ifdef AES_SEQ_WATCHDOG_EN
            timeout_q  <= 1'b0;
`endif
            aes_load_o <= 1'b1;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
            trigger_o  <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // aes_busy_i is not looked at while the load strobe is high
`ifdef AES_SEQ_WATCHDOG_EN
          wait_cnt <= 2'd0;
`endif
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (aes_busy_i) begin
            busy_cnt <= cnt_inc;
            state    <= S_RUN;
          end
`ifdef AES_SEQ_WATCHDOG_EN
          else if (wait_cnt == 2'd3) begin
            timeout_q <= 1'b1;
            cycles_o  <= busy_cnt;
            done_o    <= 1'b1;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
            trigger_o <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
`endif
        end
        S_RUN: begin
          if (!aes_busy_i) begin
            cipher_o  <= aes_data_i;
            cycles_o  <= busy_cnt;
            done_o    <= 1'b1;
            trigger_o <= 1'b0;
            state     <= S_CAPTURE;
          end
`ifdef AES_SEQ_WATCHDOG_EN
          else if (cnt_inc >= RUN_LIMIT) begin
            busy_cnt  <= cnt_inc;
            timeout_q <= 1'b1;
            cycles_o  <= cnt_inc;
            done_o    <= 1'b1;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
            trigger_o <= 1'b0;
            state     <= S_IDLE;
          end
`endif
          else begin
            busy_cnt <= cnt_inc;
          end
        end
        S_CAPTURE: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          ready_o   <= 1'b1;
          busy_o    <= 1'b0;
          trigger_o <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
